// File: rtl/alu_defs.sv
// alu_defs: ALU control codes and EX-stage state encoding shared with the ALU control decoder.
package alu_defs;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam int MUL_STEPS = 32;
    typedef enum logic {ST_IDLE, ST_MUL} ex_state_e;
endpackage

// File: rtl/seq_mult32.sv
// seq_mult32: iterative shift-add unsigned multiplier, one multiplier bit per clock.
module seq_mult32 #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               last_step_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(STEPS);
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    // product_o is the accumulator after the current step, so the final value is ready on the last edge
    always_comb begin
        acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step_o = busy_q && cnt_q == CW'(STEPS - 1);
        busy_o      = busy_q;
        product_o   = acc_d;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (abort_i) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            busy_q   <= !last_step_o;
        end
    end
endmodule

// File: rtl/ex_alu_mul.sv
// ex_alu_mul: EX-stage ALU with single-cycle logic/arith ops and a stalling iterative MUL.
module ex_alu_mul #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = alu_defs::MUL_STEPS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic             zero_o
);
    import alu_defs::*;
    ex_state_e          state_q, state_d;
    logic               valid_q, valid_d, zero_q, zero_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, op_res;
    logic               accept, start, abort, done, in_mul, busy, last_step;
    logic [2*WIDTH-1:0] product;
    seq_mult32 #(.WIDTH(WIDTH), .STEPS(MUL_STEPS)) u_mult (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start), .abort_i(abort),
        .a_i(src1_i), .b_i(src2_i), .busy_o(busy), .last_step_o(last_step), .product_o(product)
    );
    always_comb begin
        in_mul  = state_q == ST_MUL && busy;
        accept  = state_q == ST_IDLE && valid_i && !flush_i;
        start   = accept && ctrl_i == ALU_MUL;
        abort   = state_q == ST_MUL && flush_i;
        done    = in_mul && last_step && !flush_i;
        stall_o = start || (in_mul && !last_step && !flush_i);
        op_res  = ctrl_i == ALU_AND ? src1_i & src2_i :
                  ctrl_i == ALU_OR  ? src1_i | src2_i :
                  ctrl_i == ALU_ADD ? src1_i + src2_i :
                  ctrl_i == ALU_SUB ? src1_i - src2_i :
                  ctrl_i == ALU_SLT ? WIDTH'($signed(src1_i) < $signed(src2_i)) : '0;
        state_d  = start ? ST_MUL : (abort || done) ? ST_IDLE : state_q;
        valid_d  = 1'b0;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        if (accept && !start) begin
            valid_d  = 1'b1;
            result_d = op_res;
            zero_d   = op_res == '0;
        end else if (done) begin
            valid_d  = 1'b1;
            result_d = product[WIDTH-1:0];
            hi_d     = product[2*WIDTH-1:WIDTH];
            zero_d   = product[WIDTH-1:0] == '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
        end
    end
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign prod_hi_o = hi_q;
    assign zero_o    = zero_q;
endmodule

// File: tb/tb_ex_alu_mul.sv
// tb_ex_alu_mul: directed scoreboard bench for ex_alu_mul.
module tb_ex_alu_mul;
    import alu_defs::*;
    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, flush_i;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i, src2_i;
    logic        stall_o, valid_o, zero_o;
    logic [31:0] result_o, prod_hi_o;
    exp_t        q[$];
    logic [31:0] hi_exp;
    int          checks = 0, errors = 0, vcount = 0;
    ex_alu_mul dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i), .stall_o(stall_o),
        .valid_o(valid_o), .result_o(result_o), .prod_hi_o(prod_hi_o), .zero_o(zero_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [31:0] r, input logic [31:0] h);
        exp_t e;
        e.r = r;
        e.h = h;
        e.z = r == 32'd0;
        q.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (valid_o) begin
            vcount++;
            chk("queue_nonempty_on_valid", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result", result_o, e.r);
                chk("prod_hi", prod_hi_o, e.h);
                chk("zero", 32'(zero_o), 32'(e.z));
            end
        end
    endtask
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
        valid_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        push(r, hi_exp);
        #1;
        chk("stall_simple", 32'(stall_o), 32'd0);
        tick();
    endtask
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          stalls, cycles, v0;
        p = 64'(a) * 64'(b);
        hi_exp = p[63:32];
        push(p[31:0], hi_exp);
        valid_i = 1'b1;
        ctrl_i  = ALU_MUL;
        src1_i  = a;
        src2_i  = b;
        stalls = 0;
        cycles = 0;
        v0 = vcount;
        while (vcount == v0 && cycles < 40) begin
            #1;
            if (stall_o) stalls++;
            tick();
            cycles++;
        end
        valid_i = 1'b0;
        chk("mul_stall_cycles", 32'(stalls), 32'd32);
        chk("mul_latency_edges", 32'(cycles), 32'd33);
        tick();
        chk("mul_valid_pulses", 32'(vcount - v0), 32'd1);
    endtask
    initial begin
        hi_exp  = 32'd0;
        rst_i   = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = ALU_ADD;
        src1_i  = 32'd5;
        src2_i  = 32'd7;
        tick();
        tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_prod_hi", prod_hi_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b1;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0);
        issue(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
        issue(ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
        issue(4'b1111, 32'h1234_5678, 32'h1, 32'd0);
        issue(ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
        valid_i = 1'b0;
        tick();
        chk("idle_valid", 32'(valid_o), 32'd0);
        chk("idle_hold_result", result_o, 32'h0000_FFF0);
        run_mul(32'h0001_2345, 32'h0000_0010);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        valid_i = 1'b1;
        ctrl_i  = ALU_MUL;
        src1_i  = 32'd7;
        src2_i  = 32'd9;
        tick();
        repeat (10) tick();
        chk("stall_before_flush", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        #1;
        chk("stall_during_flush", 32'(stall_o), 32'd0);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_hold_result", result_o, 32'h0000_0001);
        chk("flush_hold_hi", prod_hi_o, 32'hFFFF_FFFE);
        issue(ALU_ADD, 32'd2, 32'd2, 32'd4);
        valid_i = 1'b1;
        ctrl_i  = ALU_MUL;
        src1_i  = 32'd3;
        src2_i  = 32'd5;
        tick();
        repeat (20) tick();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        tick();
        chk("mulrst_valid", 32'(valid_o), 32'd0);
        chk("mulrst_result", result_o, 32'd0);
        chk("mulrst_prod_hi", prod_hi_o, 32'd0);
        chk("mulrst_zero", 32'(zero_o), 32'd0);
        chk("mulrst_stall", 32'(stall_o), 32'd0);
        rst_i  = 1'b1;
        hi_exp = 32'd0;
        run_mul(32'h0000_1234, 32'h0000_5678);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_alu_mul.md
Name: ex_alu_mul

Overview:
- Execute-stage datapath unit. Directly downstream of the ALU control decoder: consumes its 4-bit ALU control code and the two ID/EX operands.
- Simple ops (AND/OR/ADD/SUB/SLT) complete in 1 cycle. MUL runs on an iterative 32-step shift-add multiplier and holds the pipeline with stall_o while it runs.
- Results are registered and form the EX side of the EX/MEM boundary.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_STEPS, 32, multiplier iterations; must equal WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- valid_i  input  1  a valid instruction is present in EX this cycle.
- ctrl_i  input  4  ALU control code from the ALU control decoder.
- src1_i  input  WIDTH  operand A (rs).
- src2_i  input  WIDTH  operand B (rt or immediate).
- flush_i  input  1  kill the current EX instruction, including an in-flight MUL.
- stall_o  output  1  combinational; hold PC, IF/ID and ID/EX this cycle.
- valid_o  output  1  registered; result_o holds a new result.
- result_o  output  WIDTH  registered result (low WIDTH bits for MUL).
- prod_hi_o  output  WIDTH  registered high half of the last MUL product.
- zero_o  output  1  registered; result_o == 0.

Behaviour:
- Reset (rst_i == 0 at an edge): state IDLE, step counter 0. valid_o, result_o, prod_hi_o and zero_o all 0. Reset overrides flush_i and any in-flight MUL.
- Control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT: signed; result 1 or 0, zero-extended.
  - 1000 MUL.
  - Any other code: result 0 with valid_o 1.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag, no trap.
- States: IDLE, MUL.
- IDLE, valid_i = 1, code not MUL, flush_i = 0:
  - Next edge: result_o is the op result, zero_o updated, valid_o = 1.
  - stall_o = 0. Latency 1 edge; back-to-back issue every cycle.
- IDLE, valid_i = 0 or flush_i = 1: next edge valid_o = 0; result_o, zero_o and prod_hi_o hold.
- IDLE, valid_i = 1, code MUL, flush_i = 0:
  - stall_o = 1 this cycle.
  - Next edge: latch multiplicand and multiplier, clear the 2*WIDTH accumulator, counter = 0, go to MUL, valid_o = 0.
- MUL, each edge:
  - If the multiplier LSB is 1, add the multiplicand (shifted by the counter) into the accumulator.
  - Shift the multiplier right. Counter + 1.
- stall_o in MUL: 1 while counter < MUL_STEPS-1; 0 in the cycle where counter == MUL_STEPS-1.
- Edge ending the counter == MUL_STEPS-1 cycle:
  - result_o = accumulator[WIDTH-1:0], prod_hi_o = accumulator[2*WIDTH-1:WIDTH] (unsigned product).
  - zero_o updated, valid_o = 1 for one cycle, go to IDLE.
  - The pipeline advances on this same edge.
- Stall count: a MUL presented in cycle 0 keeps stall_o high in cycles 0..31 (32 stall cycles). Its result is registered at the end of cycle 32.
- While in MUL, valid_i/ctrl_i/src*_i are ignored. Upstream holds them stable, and the held MUL is never re-accepted.
- flush_i = 1 in MUL: next edge go to IDLE, counter 0, valid_o = 0; result_o and prod_hi_o unchanged. stall_o drops combinationally in that same cycle.
- Signed MUL: the low WIDTH bits are correct for both signed and unsigned operands. prod_hi_o is defined as unsigned only.

Decomposition:
- Shared package alu_defs:
  - localparams ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_MUL = 4'b1000.
  - MUL_STEPS = 32.
  - The ALU control decoder uses the same constants.
- One sub-module: seq_mult32.
  - Ports: start, abort, operands; busy, last_step, product.
  - ex_alu_mul keeps the FSM and stall logic, the simple ops and the output registers.

Test Plan:
- Reset: hold rst_i = 0 for 2 edges with valid_i = 1, ADD, 5, 7 -> valid_o = 0, result_o = 0, zero_o = 0, stall_o = 0.
- Single-cycle ops back-to-back:
  - ADD 0xFFFFFFFF + 1 -> 0, zero_o = 1.
  - SUB 3 - 5 -> 0xFFFFFFFE.
  - SLT -1 vs 1 -> 1.
  - AND 0xF0F0 & 0x0FF0 -> 0x00F0.
  - OR -> 0xFFF0.
  - Each result one edge later; stall_o never asserted.
- MUL 0x00012345 * 0x00000010:
  - stall_o high for exactly 32 cycles starting at presentation.
  - result_o = 0x00123450 and prod_hi_o = 0 at the 33rd edge; valid_o pulses exactly once.
- MUL 0xFFFFFFFF * 0xFFFFFFFF -> result_o = 0x00000001, prod_hi_o = 0xFFFFFFFE.
- Flush at MUL step 10 -> stall_o low in the same cycle, IDLE next edge, valid_o stays 0, result_o keeps its prior value. A following ADD 2 + 2 gives 4 one edge later.
- Reset asserted at MUL step 20 -> IDLE and outputs 0 after that edge. A MUL issued afterwards completes normally with the correct product.
